// File: rtl/id_pipe_pkg.sv
// id_pipe_pkg: rv32i_types package with decode-stage enums, opcodes, control word and immediate helper
package rv32i_types;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;
  typedef enum logic [1:0] {EMPTY, FULL, BUBBLE} idstate_t;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;
  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] cmpop;
    logic       cmpmux_sel;
    logic       load_regfile;
    logic       mem_read;
    logic       mem_write;
    logic [3:0] mem_byte_en;
    imm_sel_t   imm_sel;
  } rv32i_control_word;
  function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_sel_t s);
    return s == IMM_I ? {{20{i[31]}}, i[31:20]} :
           s == IMM_S ? {{20{i[31]}}, i[31:25], i[11:7]} :
           s == IMM_B ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
           s == IMM_U ? {i[31:12], 12'h000} :
           s == IMM_J ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} : 32'h0;
  endfunction
endpackage

// File: rtl/id_pipe_decode.sv
// id_pipe_decode: control_rom (opcode to control word) and cmp (branch/set-less-than comparator)
module control_rom
  import rv32i_types::*;
(
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  output rv32i_control_word ctrl
);
  always_comb begin
    ctrl = '0;
    ctrl.opcode = opcode;
    ctrl.imm_sel = (opcode == OP_LOAD || opcode == OP_IMM || opcode == OP_JALR) ? IMM_I :
                   opcode == OP_STORE ? IMM_S :
                   opcode == OP_BR ? IMM_B :
                   (opcode == OP_LUI || opcode == OP_AUIPC) ? IMM_U :
                   opcode == OP_JAL ? IMM_J : IMM_NONE;
    ctrl.load_regfile = opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_REG};
    ctrl.mem_read = opcode == OP_LOAD;
    ctrl.mem_write = opcode == OP_STORE;
    ctrl.mem_byte_en = !(ctrl.mem_read || ctrl.mem_write) ? 4'b0000 :
                       funct3[1:0] == 2'b00 ? 4'b0001 : funct3[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
    // non-branches compare for slt/sltu: signed less-than unless funct3 selects unsigned
    ctrl.cmpop = opcode == OP_BR ? funct3 : funct3 == 3'b011 ? 3'b110 : 3'b100;
    ctrl.cmpmux_sel = opcode == OP_IMM;
  end
endmodule

module cmp #(parameter int WIDTH = 32) (
  input  logic [2:0]       cmpop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             br_en
);
  assign br_en = cmpop == 3'b000 ? a == b :
                 cmpop == 3'b001 ? a != b :
                 cmpop == 3'b100 ? $signed(a) < $signed(b) :
                 cmpop == 3'b101 ? $signed(a) >= $signed(b) :
                 cmpop == 3'b110 ? a < b :
                 cmpop == 3'b111 ? a >= b : 1'b0;
endmodule

// File: rtl/id_pipe_regfile.sv
// regfile_param: 2-read/1-write register file, x0 hardwired to 0
// ID_WB_BYPASS_EN: when defined, a same-cycle WB write is forwarded to the read ports
module regfile_param #(
  parameter  int WIDTH = 32,
  parameter  int NREG  = 32,
  localparam int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [AW-1:0]    rd,
  input  logic [WIDTH-1:0] data,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  output logic [WIDTH-1:0] rs1_data,
  output logic [WIDTH-1:0] rs2_data
);
`ifdef ID_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  logic [WIDTH-1:0] regs [NREG];
  logic fwd;
  always_ff @(posedge clk or posedge rst)
    if (rst) regs <= '{default: '0};
    else if (load && rd != '0) regs[rd] <= data;
  // regs[0] is never written, so x0 reads 0 without a separate check
  assign fwd = BYPASS && load && rd != '0;
  assign rs1_data = (fwd && rd == rs1) ? data : regs[rs1];
  assign rs2_data = (fwd && rd == rs2) ? data : regs[rs2];
endmodule

// File: rtl/id_pipe.sv
// id_pipe: RV32I decode stage with load-use bubble insertion, flush and EX handshake
module id_pipe
  import rv32i_types::*;
#(
  parameter  int WIDTH     = 32,
  parameter  int NREG      = 32,
  parameter  int STALL_MAX = 3,
  localparam int AW        = $clog2(NREG),
  localparam int SW        = $clog2(STALL_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid_i,
  input  logic [WIDTH-1:0]  if_instr_i,
  input  logic [WIDTH-1:0]  if_pc_i,
  output logic              if_ready_o,
  input  logic              wb_load_i,
  input  logic [AW-1:0]     wb_rd_i,
  input  logic [WIDTH-1:0]  wb_data_i,
  input  logic              flush_i,
  input  logic              ex_ready_i,
  output logic              ex_valid_o,
  output rv32i_control_word ex_ctrl_o,
  output logic [WIDTH-1:0]  ex_pc_o,
  output logic [WIDTH-1:0]  ex_instr_o,
  output logic [WIDTH-1:0]  ex_rs1_data_o,
  output logic [WIDTH-1:0]  ex_rs2_data_o,
  output logic [WIDTH-1:0]  ex_imm_o,
  output logic [AW-1:0]     ex_rs1_o,
  output logic [AW-1:0]     ex_rs2_o,
  output logic [AW-1:0]     ex_rd_o,
  output logic              ex_br_en_o,
  output logic [SW-1:0]     stall_cnt_o
);
  idstate_t state, state_nxt;
  rv32i_control_word ctrl;
  logic [AW-1:0] rs1, rs2, rd;
  logic [WIDTH-1:0] rs1_data, rs2_data, imm, i_imm;
  logic br_en, hazard, advance, transfer, bubble;
  assign rs1 = AW'(if_instr_i[19:15]);
  assign rs2 = AW'(if_instr_i[24:20]);
  assign rd = AW'(if_instr_i[11:7]);
  assign imm = WIDTH'(signed'(imm_gen(if_instr_i[31:0], ctrl.imm_sel)));
  assign i_imm = WIDTH'(signed'(imm_gen(if_instr_i[31:0], IMM_I)));
  control_rom u_rom (.opcode(if_instr_i[6:0]), .funct3(if_instr_i[14:12]), .ctrl(ctrl));
  regfile_param #(.WIDTH(WIDTH), .NREG(NREG)) u_rf (
    .clk(clk), .rst(rst), .load(wb_load_i), .rd(wb_rd_i), .data(wb_data_i),
    .rs1(rs1), .rs2(rs2), .rs1_data(rs1_data), .rs2_data(rs2_data)
  );
  cmp #(.WIDTH(WIDTH)) u_cmp (
    .cmpop(ctrl.cmpop), .a(rs1_data), .b(ctrl.cmpmux_sel ? i_imm : rs2_data), .br_en(br_en)
  );
  assign hazard = if_valid_i && ex_valid_o && ex_ctrl_o.mem_read && ex_rd_o != '0 &&
                  (ex_rd_o == rs1 || ex_rd_o == rs2);
  assign advance = !ex_valid_o || ex_ready_i;
  assign transfer = if_valid_i && if_ready_o && !flush_i;
  assign bubble = advance && hazard && !flush_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= EMPTY;
    else state <= state_nxt;
  always_comb state_nxt = flush_i ? EMPTY : transfer ? FULL : bubble ? BUBBLE : advance ? EMPTY : state;
  always_comb begin
    ex_valid_o = state != EMPTY;
    if_ready_o = flush_i || (advance && !hazard);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ex_ctrl_o <= '0;
      ex_pc_o <= '0;
      ex_instr_o <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o <= '0;
      ex_rs1_o <= '0;
      ex_rs2_o <= '0;
      ex_rd_o <= '0;
      ex_br_en_o <= 1'b0;
    end else if (transfer) begin
      ex_ctrl_o <= ctrl;
      ex_pc_o <= if_pc_i;
      ex_instr_o <= if_instr_i;
      ex_rs1_data_o <= rs1_data;
      ex_rs2_data_o <= rs2_data;
      ex_imm_o <= imm;
      ex_rs1_o <= rs1;
      ex_rs2_o <= rs2;
      ex_rd_o <= rd;
      ex_br_en_o <= br_en;
    end else if (bubble) ex_ctrl_o <= '0;
  // the transfer out of BUBBLE is the stalled instruction itself, so a dependent-load chain keeps counting
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_cnt_o <= '0;
    else if (flush_i) stall_cnt_o <= '0;
    else if (bubble) stall_cnt_o <= stall_cnt_o == SW'(STALL_MAX) ? stall_cnt_o : stall_cnt_o + 1'b1;
    else if (transfer && state != BUBBLE) stall_cnt_o <= '0;
endmodule

// File: tb/tb_id_pipe.sv
// tb_id_pipe: directed vector table plus hand-written hazard, backpressure, flush, bypass and reset sequences
module tb_id_pipe;
  import rv32i_types::*;
  logic clk = 1'b0, rst = 1'b0;
  logic if_valid = 1'b0, if_ready, wb_load = 1'b0, flush = 1'b0, ex_ready = 1'b1, ex_valid, ex_br_en;
  logic [31:0] if_instr = '0, if_pc = '0, wb_data = '0;
  logic [31:0] ex_pc, ex_instr, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] wb_rd = '0, ex_rs1, ex_rs2, ex_rd;
  logic [1:0] stall_cnt;
  rv32i_control_word ex_ctrl;
  int total = 0, bad = 0;

  id_pipe dut (
    .clk(clk), .rst(rst), .if_valid_i(if_valid), .if_instr_i(if_instr), .if_pc_i(if_pc),
    .if_ready_o(if_ready), .wb_load_i(wb_load), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .flush_i(flush), .ex_ready_i(ex_ready), .ex_valid_o(ex_valid), .ex_ctrl_o(ex_ctrl),
    .ex_pc_o(ex_pc), .ex_instr_o(ex_instr), .ex_rs1_data_o(ex_rs1_data), .ex_rs2_data_o(ex_rs2_data),
    .ex_imm_o(ex_imm), .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2), .ex_rd_o(ex_rd),
    .ex_br_en_o(ex_br_en), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] instr, imm, rs1d, rs2d;
    logic [4:0]  rd;
    logic        lrf, mw, chk_br, br;
  } vec_t;
  vec_t vecs[11];

  initial begin
    // x1=5, x2=7 once written through WB
    vecs[0]  = '{32'h00500093, 32'd5,        32'd0, 32'd0, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0}; // addi x1,x0,5
    vecs[1]  = '{32'h0020A423, 32'd8,        32'd5, 32'd7, 5'd8,  1'b0, 1'b1, 1'b0, 1'b0}; // sw x2,8(x1)
    vecs[2]  = '{32'hFE208EE3, 32'hFFFFFFFC, 32'd5, 32'd7, 5'd29, 1'b0, 1'b0, 1'b1, 1'b0}; // beq x1,x2,-4
    vecs[3]  = '{32'hFE209EE3, 32'hFFFFFFFC, 32'd5, 32'd7, 5'd29, 1'b0, 1'b0, 1'b1, 1'b1}; // bne
    vecs[4]  = '{32'hFE20CEE3, 32'hFFFFFFFC, 32'd5, 32'd7, 5'd29, 1'b0, 1'b0, 1'b1, 1'b1}; // blt
    vecs[5]  = '{32'hFE20FEE3, 32'hFFFFFFFC, 32'd5, 32'd7, 5'd29, 1'b0, 1'b0, 1'b1, 1'b0}; // bgeu
    vecs[6]  = '{32'h123452B7, 32'h12345000, 32'd0, 32'd0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0}; // lui x5
    vecs[7]  = '{32'h001000EF, 32'h00000800, 32'd0, 32'd5, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0}; // jal x1,2048
    vecs[8]  = '{32'h0060A313, 32'd6,        32'd5, 32'd0, 5'd6,  1'b1, 1'b0, 1'b1, 1'b1}; // slti x6,x1,6
    vecs[9]  = '{32'hFFF0B313, 32'hFFFFFFFF, 32'd5, 32'd0, 5'd6,  1'b1, 1'b0, 1'b1, 1'b1}; // sltiu x6,x1,-1
    vecs[10] = '{32'h00208233, 32'd0,        32'd5, 32'd7, 5'd4,  1'b1, 1'b0, 1'b0, 1'b0}; // add x4,x1,x2

    #2 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(ex_valid), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_pc", ex_pc, 0);
    chk("rst_ctrl", 32'(ex_ctrl), 0);
    tick();
    tick();
    rst = 1'b0;
    #1 chk("post_rst_ready", 32'(if_ready), 1);

    wb_load = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
    tick();
    wb_rd = 5'd2; wb_data = 32'd7;
    tick();
    wb_load = 1'b0;

    for (int i = 0; i < 11; i++) begin
      if_valid = 1'b1; if_instr = vecs[i].instr; if_pc = 32'(32'h100 + 4 * i);
      tick();
      chk($sformatf("v%0d_valid", i), 32'(ex_valid), 1);
      chk($sformatf("v%0d_pc", i), ex_pc, 32'(32'h100 + 4 * i));
      chk($sformatf("v%0d_imm", i), ex_imm, vecs[i].imm);
      chk($sformatf("v%0d_rd", i), 32'(ex_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_rs1d", i), ex_rs1_data, vecs[i].rs1d);
      chk($sformatf("v%0d_rs2d", i), ex_rs2_data, vecs[i].rs2d);
      chk($sformatf("v%0d_lrf", i), 32'(ex_ctrl.load_regfile), 32'(vecs[i].lrf));
      chk($sformatf("v%0d_mw", i), 32'(ex_ctrl.mem_write), 32'(vecs[i].mw));
      if (vecs[i].chk_br) chk($sformatf("v%0d_br", i), 32'(ex_br_en), 32'(vecs[i].br));
    end
    if_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(ex_valid), 0);

    // backpressure: EX stalls three cycles while FULL
    if_valid = 1'b1; if_instr = 32'h00500093; if_pc = 32'h200;
    tick();
    ex_ready = 1'b0; if_instr = 32'h00208233; if_pc = 32'h204;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("bp%0d_ready", c), 32'(if_ready), 0);
      tick();
      chk($sformatf("bp%0d_pc", c), ex_pc, 32'h200);
      chk($sformatf("bp%0d_imm", c), ex_imm, 32'd5);
      chk($sformatf("bp%0d_valid", c), 32'(ex_valid), 1);
    end
    ex_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(if_ready), 1);
    tick();
    chk("bp_release_pc", ex_pc, 32'h204);
    if_valid = 1'b0;
    tick();

    // load-use hazard: lw x2,0(x1) then add x3,x2,x2
    if_valid = 1'b1; if_instr = 32'h0000A103; if_pc = 32'h300;
    tick();
    chk("lw_mem_read", 32'(ex_ctrl.mem_read), 1);
    chk("lw_rd", 32'(ex_rd), 2);
    if_instr = 32'h002101B3; if_pc = 32'h304;
    #1 chk("hz_ready", 32'(if_ready), 0);
    tick();
    chk("bub_valid", 32'(ex_valid), 1);
    chk("bub_ctrl", 32'(ex_ctrl), 0);
    chk("bub_stall", 32'(stall_cnt), 1);
    chk("bub_ready", 32'(if_ready), 1);
    tick();
    chk("add_pc", ex_pc, 32'h304);
    chk("add_rd", 32'(ex_rd), 3);
    chk("add_rs1d", ex_rs1_data, 32'd7);
    if_instr = 32'h00500093; if_pc = 32'h308;
    tick();
    chk("after_stall", 32'(stall_cnt), 0);
    chk("after_pc", ex_pc, 32'h308);

    // flush while FULL with a valid incoming instruction
    if_instr = 32'h00208233; if_pc = 32'h30C; flush = 1'b1;
    #1 chk("flush_ready", 32'(if_ready), 1);
    tick();
    chk("flush_valid", 32'(ex_valid), 0);
    chk("flush_state", 32'(dut.state), 0);
    flush = 1'b0; if_valid = 1'b0;
    tick();

    // WB write to x1 while decoding add x4,x1,x0
    wb_load = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEADBEEF;
    if_valid = 1'b1; if_instr = 32'h00008233; if_pc = 32'h400;
    tick();
`ifdef ID_WB_BYPASS_EN
    chk("wb_same_cycle", ex_rs1_data, 32'hDEADBEEF);
`else
    chk("wb_same_cycle", ex_rs1_data, 32'd5);
`endif
    wb_load = 1'b0;
    tick();
    chk("wb_next_cycle", ex_rs1_data, 32'hDEADBEEF);
    wb_load = 1'b1; wb_rd = 5'd0; wb_data = 32'h00001234; if_instr = 32'h00000233;
    tick();
    chk("x0_same_rs1", ex_rs1_data, 0);
    chk("x0_same_rs2", ex_rs2_data, 0);
    wb_load = 1'b0;
    tick();
    chk("x0_later", ex_rs1_data, 0);
    if_valid = 1'b0;
    tick();

    // dependent load chain saturates the bubble counter, then async reset
    if_valid = 1'b1; if_instr = 32'h0000A103; if_pc = 32'h500;
    tick();
    if_instr = 32'h00012103; if_pc = 32'h504;
    tick();
    chk("chain_stall1", 32'(stall_cnt), 1);
    tick();
    tick();
    chk("chain_stall2", 32'(stall_cnt), 2);
    tick();
    tick();
    chk("chain_stall3", 32'(stall_cnt), 3);
    tick();
    tick();
    chk("sat_stall", 32'(stall_cnt), 3);
    chk("sat_valid", 32'(ex_valid), 1);
    chk("sat_ctrl", 32'(ex_ctrl), 0);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(ex_valid), 0);
    chk("arst_stall", 32'(stall_cnt), 0);
    chk("arst_pc", ex_pc, 0);
    if_instr = 32'h00008233; if_pc = 32'h600;
    tick();
    chk("in_rst_valid", 32'(ex_valid), 0);
    rst = 1'b0;
    tick();
    chk("first_xfer_valid", 32'(ex_valid), 1);
    chk("first_xfer_rd", 32'(ex_rd), 4);
    chk("regs_cleared", ex_rs1_data, 0);
    if_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
